// File: rtl/cmp_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and the
// one-hot {lt, eq, gt} result word.
package cmp_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMP  = 1'b1;

  typedef logic [2:0] res_t;

  // Bit order is {lt, eq, gt}; all-zero means no result yet.
  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_LT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_GT   = 3'b001;

endpackage

// File: rtl/cmp_slice.sv
// Combinational magnitude compare of one SLICE-wide operand pair.
module cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt
);

  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/seq_comparator.sv
// Serial MSB-first comparator: one SLICE per cycle through a single slice
// comparator, stopping at the first differing slice, with a cascade tie-break.
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_lt_in,
  input  logic             i_eq_in,
  input  logic             i_gt_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_lt_out,
  output logic             o_eq_out,
  output logic             o_gt_out
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam int POS_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;
  res_t             r_res;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  res_t             r_tie;

  logic [POS_W-1:0] w_base;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  res_t             w_tie;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && i_start;

  // Tie-break priority GT > LT > EQ, resolved once at capture time.
  always_comb begin
    casez ({i_gt_in, i_lt_in, i_eq_in})
      3'b1??:  w_tie = RES_GT;
      3'b01?:  w_tie = RES_LT;
      default: w_tie = RES_EQ;
    endcase
  end

  // Signed order equals unsigned order once both sign bits are flipped, so the
  // flip is folded into the capture and the slice compare stays unsigned.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_a   <= i_a ^ {i_signed_mode, {(WIDTH-1){1'b0}}};
      r_b   <= i_b ^ {i_signed_mode, {(WIDTH-1){1'b0}}};
      r_tie <= w_tie;
    end
  end

  always_comb begin
    w_base = POS_W'(WIDTH - 1 - SLICE * int'(r_idx));
    w_sa   = r_a[w_base -: SLICE];
    w_sb   = r_b[w_base -: SLICE];
  end

  cmp_slice #(
    .SLICE (SLICE)
  ) u_cmp_slice (
    .i_a  (w_sa),
    .i_b  (w_sb),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_res   <= RES_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CMP;
            r_idx   <= '0;
          end
        end
        default: begin
          if (!w_eq) begin
            r_res   <= w_gt ? RES_GT : RES_LT;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else if (r_idx == LAST_IDX) begin
            r_res   <= r_tie;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_busy   = (r_state == S_CMP);
  assign o_done   = r_done;
  assign o_lt_out = r_res[2];
  assign o_eq_out = r_res[1];
  assign o_gt_out = r_res[0];

  // w_lt is implied by !w_eq && !w_gt; kept on the port for completeness.
  logic w_unused;
  assign w_unused = w_lt;

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits.
REQ-002 Parameter SLICE, default 4: bits compared per cycle; WIDTH SHALL be an integer multiple of SLICE; NSLICES = WIDTH/SLICE.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  request; sampled only while BUSY=0.
REQ-006 SIGNED_MODE  input  1  1 = two's-complement compare, 0 = unsigned; captured with START.
REQ-007 A, B  input  WIDTH  operands; captured with START.
REQ-008 LT_IN, EQ_IN, GT_IN  input  1 each  cascade tie-break from a less-significant stage; captured with START.
REQ-009 BUSY  output  1  high while a compare is in progress.
REQ-010 DONE  output  1  one-cycle pulse: result valid and updated.
REQ-011 LT_OUT, EQ_OUT, GT_OUT  output  1 each  registered result, one-hot after the first completion.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and CMP.
REQ-013 IDLE, START=1 at edge k: capture A, B, SIGNED_MODE and tie-break inputs; set slice index j=0 (MSB slice); go to CMP; BUSY=1 from edge k.
REQ-014 CMP, at edge k+1+j: compare captured slice j (bits WIDTH-1-j*SLICE down to WIDTH-(j+1)*SLICE) of A against B.
REQ-015 Slice A>B: GT_OUT=1, others 0. Slice A<B: LT_OUT=1, others 0. In both cases DONE=1 and state IDLE at the same edge (early termination).
REQ-016 Slices equal and j<NSLICES-1: increment j; stay in CMP; result outputs unchanged.
REQ-017 Slices equal and j=NSLICES-1: apply tie-break; GT_IN=1 gives GT, else LT_IN=1 gives LT, else EQ; DONE=1; go to IDLE.
REQ-018 Signed mode SHALL invert the top bit of both operands in slice 0 only before comparing; unsigned mode SHALL leave it unchanged.
REQ-019 Latency: DONE SHALL be high in the cycle after edge k+1+j, where j is the deciding slice; minimum 1 cycle, maximum NSLICES cycles.
REQ-020 DONE SHALL be high for exactly one cycle per accepted START; BUSY=0 in that cycle.
REQ-021 START in the DONE cycle SHALL be accepted as a new request (back-to-back operation).
REQ-022 START while BUSY=1 SHALL be ignored; changes to A, B, SIGNED_MODE or the tie-break inputs during CMP SHALL NOT affect the result.
REQ-023 Result outputs SHALL hold their value until the next DONE.

Reset
REQ-024 RST=1 SHALL immediately force state IDLE, j=0, BUSY=0, DONE=0, LT_OUT=EQ_OUT=GT_OUT=0, independent of CLK.
REQ-025 Reset during CMP SHALL abort the operation; no DONE SHALL follow for the aborted request.
REQ-026 The first START after reset release SHALL behave as in REQ-013.

Structure
REQ-027 A shared package cmp_pkg SHALL hold the state encoding (IDLE, CMP) and the result encoding constants (LT, EQ, GT).
REQ-028 One combinational sub-module, cmp_slice, SHALL compare one SLICE-wide pair and give lt/eq/gt; seq_comparator SHALL instantiate it once and multiplex slices into it by j.
REQ-029 Slice selection SHALL be an indexed part-select; no WIDTH-wide comparator SHALL be synthesised.

Verification (WIDTH=16, SLICE=4)
REQ-030 Unsigned, A=0x1234, B=0x1235, EQ_IN=1 -> LT_OUT=1, DONE in the 4th cycle after START is sampled.
REQ-031 A=0x8000, B=0x0001: unsigned -> GT, signed -> LT; both DONE 1 cycle after START (early exit on slice 0).
REQ-032 A=B=0xABCD: GT_IN=1 -> GT; LT_IN=1 -> LT; GT_IN=LT_IN=1 -> GT; all zero -> EQ; each DONE after 4 cycles.
REQ-033 START with A=0x0F00, B=0x0E00; during CMP, change A to 0x0000 and pulse START -> single DONE, result GT, second START ignored.
REQ-034 Assert RST while j=2 -> all outputs 0 and BUSY=0 immediately, no DONE; the next START with A=B=0 and no tie-break -> EQ after 4 cycles.
REQ-035 Back-to-back: START held high continuously -> a new request is accepted in each DONE cycle; no cycle is lost between operations.
